// File: rtl/uart_tx_ctrl.sv
// UART transmit sequencer: start bit, DATA_WIDTH data bits LSB first, optional parity, STOP_BITS stop bits.
// Define UART_TX_PARITY_EN to compile in the parity bit (PARITY_ODD selects odd parity).
module uart_tx_ctrl #(
    parameter int CLKS_PER_BIT = 434,
    parameter int DATA_WIDTH   = 8,
    parameter int STOP_BITS    = 1,
    parameter int PARITY_ODD   = 0
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic [DATA_WIDTH-1:0] tx_data,
    input  logic                  tx_valid,
    output logic                  tx_ready,
    output logic                  tx,
    output logic                  busy,
    output logic                  tx_done
);

    localparam int BAUD_W = $clog2(CLKS_PER_BIT);
    localparam int BIT_W  = $clog2(DATA_WIDTH + 1);

    localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);
    localparam logic [BIT_W-1:0]  DATA_LAST = BIT_W'(DATA_WIDTH - 1);
    localparam logic [BIT_W-1:0]  STOP_LAST = BIT_W'(STOP_BITS - 1);

    if (CLKS_PER_BIT < 2 || DATA_WIDTH < 5 || DATA_WIDTH > 9 ||
        !(STOP_BITS inside {1, 2}) || !(PARITY_ODD inside {0, 1})) begin : g_bad_params
        $error("uart_tx_ctrl: illegal parameter value");
    end

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_PARITY,
        S_STOP
    } state_t;

    state_t                state, state_next;
    logic [BAUD_W-1:0]     baud_cnt, baud_next;
    logic [BIT_W-1:0]      bit_cnt, bit_next;
    logic [DATA_WIDTH-1:0] shreg, shreg_next;
    logic                  tx_next;
    logic                  done_next;
    logic                  bit_end;
`ifdef UART_TX_PARITY_EN
    logic                  parity_bit, parity_next;
`endif

    // NOTE: every variable gets a default before the case so no path leaves one unassigned (no latches).
    always_comb begin
        state_next = state;
        baud_next  = '0;
        bit_next   = bit_cnt;
        shreg_next = shreg;
        done_next  = 1'b0;
        bit_end    = (baud_cnt == BAUD_LAST);
`ifdef UART_TX_PARITY_EN
        parity_next = parity_bit;
`endif

        if (state != S_IDLE) begin
            baud_next = bit_end ? '0 : baud_cnt + 1'b1;
        end

        case (state)
            S_IDLE: begin
                if (tx_valid) begin
                    shreg_next = tx_data;
                    state_next = S_START;
`ifdef UART_TX_PARITY_EN
                    parity_next = (PARITY_ODD != 0) ? ~^tx_data : ^tx_data;
`endif
                end
            end
            S_START: begin
                if (bit_end) state_next = S_DATA;
            end
            S_DATA: begin
                if (bit_end) begin
                    shreg_next = shreg >> 1;
                    if (bit_cnt == DATA_LAST) begin
                        bit_next = '0;
`ifdef UART_TX_PARITY_EN
                        state_next = S_PARITY;
`else
                        state_next = S_STOP;
`endif
                    end else begin
                        bit_next = bit_cnt + 1'b1;
                    end
                end
            end
`ifdef UART_TX_PARITY_EN
            S_PARITY: begin
                if (bit_end) state_next = S_STOP;
            end
`endif
            S_STOP: begin
                if (bit_end) begin
                    if (bit_cnt == STOP_LAST) begin
                        bit_next   = '0;
                        state_next = S_IDLE;
                        done_next  = 1'b1;
                    end else begin
                        bit_next = bit_cnt + 1'b1;
                    end
                end
            end
            default: begin
                state_next = S_IDLE;
                bit_next   = '0;
            end
        endcase

        // tx is registered, so it is derived from the state and shift register being entered.
        case (state_next)
            S_START: tx_next = 1'b0;
            S_DATA:  tx_next = shreg_next[0];
`ifdef UART_TX_PARITY_EN
            S_PARITY: tx_next = parity_next;
`endif
            default: tx_next = 1'b1;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
    always_ff @(posedge clock) begin
        if (reset) begin
            state    <= S_IDLE;
            baud_cnt <= '0;
            bit_cnt  <= '0;
            shreg    <= '0;
            tx       <= 1'b1;
            tx_done  <= 1'b0;
`ifdef UART_TX_PARITY_EN
            parity_bit <= 1'b0;
`endif
        end else begin
            state    <= state_next;
            baud_cnt <= baud_next;
            bit_cnt  <= bit_next;
            shreg    <= shreg_next;
            tx       <= tx_next;
            tx_done  <= done_next;
`ifdef UART_TX_PARITY_EN
            parity_bit <= parity_next;
`endif
        end
    end

    assign tx_ready = (state == S_IDLE);
    assign busy     = (state != S_IDLE);

endmodule

// File: tb/tb_uart_tx_ctrl.sv
// Scoreboard bench for uart_tx_ctrl: two instances (1 and 2 stop bits, even/odd parity) with random traffic.
// Honours UART_TX_PARITY_EN the same way the design does.
module tb_uart_tx_ctrl;

    localparam int CPB = 4;
    localparam int DW  = 8;
`ifdef UART_TX_PARITY_EN
    localparam int PAR = 1;
`else
    localparam int PAR = 0;
`endif

    typedef struct {
        logic [7:0] word;
        int         gap;
    } item_t;

    typedef struct {
        logic [7:0] word;
        int         start;
    } exp_t;

    logic       clock = 1'b0;
    logic       reset;
    logic [7:0] data_w  [2];
    logic       valid_w [2];
    logic       ready_w [2];
    logic       tx_w    [2];
    logic       busy_w  [2];
    logic       done_w  [2];

    int    cyc = 0;
    int    vectors = 0;
    int    miscompares = 0;
    item_t stim_q [2][$];
    exp_t  exp_q  [2][$];

    always #5 clock = ~clock;
    always @(posedge clock) cyc <= cyc + 1;

    uart_tx_ctrl #(.CLKS_PER_BIT(CPB), .DATA_WIDTH(DW), .STOP_BITS(1), .PARITY_ODD(0)) dut_a (
        .clock(clock), .reset(reset), .tx_data(data_w[0]), .tx_valid(valid_w[0]),
        .tx_ready(ready_w[0]), .tx(tx_w[0]), .busy(busy_w[0]), .tx_done(done_w[0])
    );

    uart_tx_ctrl #(.CLKS_PER_BIT(CPB), .DATA_WIDTH(DW), .STOP_BITS(2), .PARITY_ODD(1)) dut_b (
        .clock(clock), .reset(reset), .tx_data(data_w[1]), .tx_valid(valid_w[1]),
        .tx_ready(ready_w[1]), .tx(tx_w[1]), .busy(busy_w[1]), .tx_done(done_w[1])
    );

    function automatic int stop_bits(input int k);
        return (k == 0) ? 1 : 2;
    endfunction

    function automatic int frame_len(input int k);
        return (1 + DW + PAR + stop_bits(k)) * CPB;
    endfunction

    // Reference line waveform: list the frame's bit levels, then stretch each over CPB cycles.
    function automatic logic [63:0] exp_wave(input int k, input logic [7:0] w);
        logic [63:0] wave = '0;
        bit          bits[$];
        bits.push_back(1'b0);
        for (int i = 0; i < DW; i++) bits.push_back(w[i]);
        if (PAR == 1) bits.push_back((^w) ^ (k == 1));
        for (int i = 0; i < stop_bits(k); i++) bits.push_back(1'b1);
        for (int i = 0; i < bits.size() * CPB; i++) wave[i] = bits[i / CPB];
        return wave;
    endfunction

    task automatic check(input bit ok, input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (!ok) begin
            miscompares++;
            $display("FAIL %s at cycle %0d: got %0h, wanted %0h", name, cyc, act, exp);
        end
    endtask

    task automatic drive(input int k);
        item_t it;
        int    prev_start = -1;
        int    budget;
        int    start;
        exp_t  e;
        while (stim_q[k].size() > 0) begin
            it = stim_q[k].pop_front();
            if (it.gap > 0) begin
                valid_w[k] = 1'b0;
                repeat (it.gap) @(negedge clock);
            end
            data_w[k]  = it.word;
            valid_w[k] = 1'b1;
            budget = 0;
            while (!ready_w[k] && budget < 200) begin
                @(negedge clock);
                budget++;
            end
            if (!ready_w[k]) begin
                check(1'b0, "ready_timeout", 64'(budget), 64'd200);
                valid_w[k] = 1'b0;
                return;
            end
            // Held valid must be taken in the first idle cycle after the previous frame.
            start = (it.gap == 0 && prev_start >= 0) ? prev_start + frame_len(k) + 1 : cyc + 1;
            e.word  = it.word;
            e.start = start;
            exp_q[k].push_back(e);
            prev_start = start;
            @(posedge clock);
            @(negedge clock);
            data_w[k] = 8'($urandom);
        end
        @(negedge clock);
        valid_w[k] = 1'b0;
    endtask

    task automatic monitor(input int k);
        exp_t        e;
        logic [63:0] wav, bsy, rdy, dn, mask, ew;
        int          len;
        bit          have;
        forever begin
            @(negedge clock);
            if (tx_w[k] === 1'b0) begin
                len  = frame_len(k);
                mask = (64'd1 << len) - 64'd1;
                wav = '0; bsy = '0; rdy = '0; dn = '0;
                have = exp_q[k].size() > 0;
                if (have) e = exp_q[k].pop_front();
                else begin
                    e.word  = '0;
                    e.start = -1;
                end
                check(have, $sformatf("unexpected_frame%0d", k), 64'(cyc), 64'(e.start));
                if (have) check(cyc == e.start, $sformatf("start_cycle%0d", k), 64'(cyc), 64'(e.start));
                for (int i = 0; i < len; i++) begin
                    if (i > 0) @(negedge clock);
                    wav[i] = tx_w[k];
                    bsy[i] = busy_w[k];
                    rdy[i] = ready_w[k];
                    dn[i]  = done_w[k];
                end
                ew = exp_wave(k, e.word);
                check(wav == ew, $sformatf("frame%0d_tx_%02h", k, e.word), wav, ew);
                check(bsy == mask, $sformatf("frame%0d_busy", k), bsy, mask);
                check(rdy == '0, $sformatf("frame%0d_ready", k), rdy, 64'd0);
                check(dn == '0, $sformatf("frame%0d_early_done", k), dn, 64'd0);
                @(negedge clock);
                check({done_w[k], busy_w[k], ready_w[k], tx_w[k]} == 4'b1011,
                      $sformatf("frame%0d_end", k),
                      64'({done_w[k], busy_w[k], ready_w[k], tx_w[k]}), 64'b1011);
            end else begin
                check(done_w[k] == 1'b0, $sformatf("idle_done%0d", k), 64'(done_w[k]), 64'd0);
            end
        end
    endtask

    initial begin
        bit   saw_done;
        bit   saw_low;
        int   budget;
        item_t it;

        reset = 1'b1;
        for (int k = 0; k < 2; k++) begin
            valid_w[k] = 1'b0;
            data_w[k]  = '0;
        end
        repeat (3) @(posedge clock);
        @(negedge clock);
        for (int k = 0; k < 2; k++)
            check({tx_w[k], ready_w[k], busy_w[k], done_w[k]} == 4'b1100, $sformatf("reset_state%0d", k),
                  64'({tx_w[k], ready_w[k], busy_w[k], done_w[k]}), 64'b1100);
        reset = 1'b0;
        @(negedge clock);

        // Abandon a frame of 0x55 mid-DATA with a one-cycle reset.
        data_w[0]  = 8'h55;
        valid_w[0] = 1'b1;
        @(posedge clock);
        @(negedge clock);
        valid_w[0] = 1'b0;
        repeat (9) @(negedge clock);
        check(busy_w[0] == 1'b1, "pre_reset_busy", 64'(busy_w[0]), 64'd1);
        reset = 1'b1;
        @(negedge clock);
        reset = 1'b0;
        check({tx_w[0], ready_w[0], busy_w[0], done_w[0]} == 4'b1100, "mid_frame_reset",
              64'({tx_w[0], ready_w[0], busy_w[0], done_w[0]}), 64'b1100);
        saw_done = 1'b0;
        saw_low  = 1'b0;
        repeat (60) begin
            @(negedge clock);
            saw_done |= done_w[0];
            saw_low  |= ~tx_w[0];
        end
        check({saw_done, saw_low} == 2'b00, "abandoned_frame_quiet", 64'({saw_done, saw_low}), 64'd0);

        stim_q[0].push_back('{8'h0F, 2});
        stim_q[0].push_back('{8'hA5, 3});
        stim_q[0].push_back('{8'h3C, 1});
        stim_q[0].push_back('{8'hFF, 0});
        stim_q[0].push_back('{8'h01, 2});
        stim_q[0].push_back('{8'h12, 1});
        stim_q[1].push_back('{8'h00, 1});
        stim_q[1].push_back('{8'hA5, 2});
        stim_q[1].push_back('{8'h01, 0});
        stim_q[1].push_back('{8'hFF, 1});
        for (int k = 0; k < 2; k++) begin
            for (int i = 0; i < 10; i++) begin
                it.word = 8'($urandom);
                it.gap  = int'($urandom_range(0, 3));
                stim_q[k].push_back(it);
            end
        end

        fork
            monitor(0);
            monitor(1);
        join_none
        fork
            drive(0);
            drive(1);
        join

        budget = 0;
        while ((exp_q[0].size() + exp_q[1].size()) > 0 && budget < 2000) begin
            @(negedge clock);
            budget++;
        end
        check((exp_q[0].size() + exp_q[1].size()) == 0, "drain_timeout",
              64'(exp_q[0].size() + exp_q[1].size()), 64'd0);
        repeat (frame_len(1) + 4) @(negedge clock);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/uart_tx_ctrl.md
Name: uart_tx_ctrl

Overview:
- UART transmit sequencer. Accepts one parallel word per valid/ready handshake and serialises it onto the tx line.
- Frame: start bit, DATA_WIDTH data bits LSB first, optional parity bit, STOP_BITS stop bits.
- Owns the baud divider, bit counter and parallel-in/serial-out shift state.
- Sits between the host-side command logic and the UART pin; companion to the receive path that uses the synchroniser and the serial-in/parallel-out register.

Parameters:
- CLKS_PER_BIT, 434, clock cycles per serial bit; legal range >= 2 (434 = 50 MHz / 115200).
- DATA_WIDTH, 8, data bits per frame; legal range 5..9.
- STOP_BITS, 1, stop bits per frame; legal values 1 or 2.
- PARITY_ODD, 0, 0 = even parity, 1 = odd parity; used only when parity is compiled in.

Ports:
- clock  input  1  system clock; all state updates on posedge.
- reset  input  1  synchronous, active-high reset.
- tx_data  input  DATA_WIDTH  word to send; sampled only on an accepted handshake.
- tx_valid  input  1  host has a word on tx_data.
- tx_ready  output  1  controller can accept a word; high only in IDLE.
- tx  output  1  serial line; idle level 1.
- busy  output  1  frame in progress; high in any state other than IDLE.
- tx_done  output  1  one-cycle pulse when a frame completes.

Behaviour:
- Clock and reset: one clock (clock). Reset is synchronous and active-high (reset).
- Reset values: state=IDLE, tx=1, tx_ready=1, busy=0, tx_done=0, baud counter=0, bit counter=0, shift register=0.
- Reset mid-frame: on the next clock edge tx=1 and state=IDLE; the partial frame is abandoned with no tx_done pulse.
- States: IDLE -> START -> DATA -> [PARITY] -> STOP -> IDLE.
- Handshake: a word is accepted on any edge where tx_valid && tx_ready.
  - tx_data is latched into the internal shift register.
  - Parity is computed from the latched word.
  - Next state is START.
- tx_data changes after acceptance have no effect. tx_valid held high with tx_ready low is ignored and does not queue.
- Baud counter:
  - Counts 0..CLKS_PER_BIT-1 in every non-IDLE state.
  - bit_end = (count == CLKS_PER_BIT-1); the counter wraps to 0 on bit_end.
  - The counter is held at 0 in IDLE.
- START: tx=0 for CLKS_PER_BIT cycles.
- DATA:
  - tx = shift register bit 0.
  - On bit_end the shift register shifts right by 1 and the bit counter increments.
  - After DATA_WIDTH bits, the bit counter clears and the state advances.
- PARITY (compiled in only): tx = parity bit for CLKS_PER_BIT cycles.
- STOP:
  - tx=1 for STOP_BITS*CLKS_PER_BIT cycles; the bit counter counts stop bits.
  - On the final bit_end: next state is IDLE and tx_done=1 for exactly that one following cycle.
- Timing:
  - tx is registered. The first cycle of the start bit is the cycle after acceptance (latency 1).
  - Frame length is (1 + DATA_WIDTH + P + STOP_BITS) * CLKS_PER_BIT cycles, where P = 1 if parity is compiled in, else 0.
  - tx_ready = (state == IDLE). It rises in the same cycle as tx_done.
  - Back-to-back: tx_valid held high is accepted in that same first IDLE cycle. Minimum gap is one idle cycle (tx=1) between frames.
- Widths:
  - Baud counter width is $clog2(CLKS_PER_BIT).
  - Bit counter width is $clog2(DATA_WIDTH+1), which is also wide enough to count STOP_BITS.
  - No counter may overflow or wrap except at its defined terminal count.

Optional Feature:
- Macro: UART_TX_PARITY_EN.
- Defined: the PARITY state is present after DATA.
  - Even parity (PARITY_ODD=0): parity bit = ^data. Odd parity: ~^data.
  - Frame is one bit longer.
- Undefined: the PARITY state and parity logic are absent. DATA goes directly to STOP and PARITY_ODD is ignored.

Test Plan:
- Reset, then CLKS_PER_BIT=4, no parity, send 0xA5 -> tx: 4 cycles of 0, then 1,0,1,0,0,1,0,1 (4 cycles each), then 4 cycles of 1. tx_done pulses once at cycle 41 after acceptance. busy is high for 40 cycles.
- Same setup, tx_valid held high with 0x3C then 0xFF queued -> second start bit begins exactly 2 cycles after the first frame's last stop cycle (one idle cycle of tx=1). No word is lost or duplicated.
- UART_TX_PARITY_EN defined, PARITY_ODD=0, send 0xA5 -> parity bit 0. Send 0x01 -> parity bit 1. PARITY_ODD=1, send 0xA5 -> parity bit 1. Frame length is 44 cycles.
- Assert reset for 1 cycle during the DATA state of frame 0x55 -> tx=1, tx_ready=1, busy=0 on the next edge. No tx_done pulse. The next word 0x0F transmits a correct full frame.
- STOP_BITS=2, CLKS_PER_BIT=4, send 0x00 -> tx low for 36 cycles (start plus 8 data bits), then high for 8 cycles before tx_done.
- tx_data changed from 0x12 to 0xEE one cycle after acceptance -> the serial frame carries 0x12.
